// File: rtl/serial_receiver.sv
// UART 8N1 byte receiver feeding an 8-byte frame decoder that publishes a
// 17-bit payload and a 24-bit timestamp once a whole frame has been validated.
module serial_receiver #(
  parameter int CLKS_PER_BIT = 104,
  parameter int IDLE_BITS    = 20
) (
  input  logic        clk_12MHz,
  input  logic        rstn,
  input  logic        rx,
  output logic [16:0] decoded_data,
  output logic [23:0] timestamp,
  output logic        frame_valid,
  output logic        frame_error
);

  localparam int TMR_W      = $clog2(CLKS_PER_BIT);
  localparam int IDLE_LIMIT = CLKS_PER_BIT * IDLE_BITS;
  localparam int IDL_W      = $clog2(IDLE_LIMIT + 1);
  localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] BIT_M1  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDL_W-1:0] IDLE_MAX = IDL_W'(IDLE_LIMIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             rx_meta_q, rx_sync_q, rx_s;
  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_done, stop_err;
  logic [IDL_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             idle_sat;
  logic [2:0]       idx_q, idx_d;
  logic [16:0]      pay_sh_q, pay_sh_d, data_q, data_d;
  logic [23:0]      ts_sh_q, ts_sh_d, ts_q, ts_d;
  logic             valid_q, valid_d, err_q, err_d;

  always_ff @(posedge clk_12MHz) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end
  assign rx_s = rx_sync_q;

  always_ff @(posedge clk_12MHz) begin
    if (!rstn) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      idle_cnt_q <= '0;
      idx_q      <= '0;
      pay_sh_q   <= '0;
      ts_sh_q    <= '0;
      data_q     <= '0;
      ts_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      idle_cnt_q <= idle_cnt_d;
      idx_q      <= idx_d;
      pay_sh_q   <= pay_sh_d;
      ts_sh_q    <= ts_sh_d;
      data_q     <= data_d;
      ts_q       <= ts_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Byte receiver: start bit is re-checked at mid-bit, later bits sampled a full bit apart.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tmr_d   = '0;
        end
      end
      START: begin
        if (tmr_q == HALF_M1) begin
          tmr_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DATA: begin
        if (tmr_q == BIT_M1) begin
          tmr_d     = '0;
          shreg_d   = {rx_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      STOP: begin
        if (tmr_q == BIT_M1) begin
          tmr_d   = '0;
          state_d = IDLE;
          if (rx_s) byte_done = 1'b1;
          else      stop_err  = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle_cnt_d = '0;
    if (state_q == IDLE && rx_s)
      idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
  end
  assign idle_sat = (idle_cnt_q == IDLE_MAX);

  // Frame decoder: bytes 0 and 3 are vetted as they arrive, byte 7 commits the frame.
  always_comb begin
    idx_d    = idx_q;
    pay_sh_d = pay_sh_q;
    ts_sh_d  = ts_sh_q;
    data_d   = data_q;
    ts_d     = ts_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (stop_err) begin
      err_d = 1'b1;
      idx_d = '0;
    end else if (byte_done) begin
      idx_d = idx_q + 1'b1;
      unique case (idx_q)
        3'd0: begin
          if (shreg_q[7:1] != 7'd0) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            pay_sh_d[16] = shreg_q[0];
          end
        end
        3'd1: pay_sh_d[15:8] = shreg_q;
        3'd2: pay_sh_d[7:0]  = shreg_q;
        3'd3: begin
          if (shreg_q != 8'd0) begin
            err_d = 1'b1;
            idx_d = '0;
          end
        end
        3'd4: ts_sh_d[23:16] = shreg_q;
        3'd5: ts_sh_d[15:8]  = shreg_q;
        3'd6: ts_sh_d[7:0]   = shreg_q;
        3'd7: begin
          if (shreg_q == 8'd0) begin
            valid_d = 1'b1;
            data_d  = pay_sh_q;
            ts_d    = ts_sh_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: idx_d = '0;
      endcase
    end else if (idle_sat) begin
      idx_d = '0;
    end
  end

  assign decoded_data = data_q;
  assign timestamp    = ts_q;
  assign frame_valid  = valid_q;
  assign frame_error  = err_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: directed frame table, multi-cycle corner sequences
// and randomized frames scored against a byte-stream model of the frame rules.
module tb_serial_receiver;

  localparam int CPB = 16;
  localparam int IB  = 20;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx;
  logic [16:0] decoded_data;
  logic [23:0] timestamp;
  logic        frame_valid;
  logic        frame_error;

  serial_receiver #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IB)) dut (
    .clk_12MHz   (clk),
    .rstn        (rstn),
    .rx          (rx),
    .decoded_data(decoded_data),
    .timestamp   (timestamp),
    .frame_valid (frame_valid),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct packed {
    logic        v;
    logic [16:0] d;
    logic [23:0] t;
  } ev_t;

  int  nvalid = 0, nerr = 0, overlap = 0;
  bit  rec_en = 1'b0;
  ev_t obs_q[$];

  always @(negedge clk) begin
    if (frame_valid && frame_error) overlap++;
    if (frame_valid) begin
      nvalid++;
      if (rec_en) obs_q.push_back({1'b1, decoded_data, timestamp});
    end
    if (frame_error) begin
      nerr++;
      if (rec_en) obs_q.push_back({1'b0, 17'h0, 24'h0});
    end
  end

  int compared = 0, failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    if (good_stop) drive_bit(1'b1, CPB);
    else begin
      drive_bit(1'b0, CPB * 3 / 4);
      drive_bit(1'b1, CPB - CPB * 3 / 4 + CPB);
    end
  endtask

  task automatic send_bytes(input logic [63:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b[63 - 8*i -: 8], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    drive_bit(1'b1, n * CPB);
  endtask

  // Byte-stream reference: a frame is whatever bytes arrived since the last resync.
  logic [7:0]  mq[$];
  ev_t         exp_q[$];
  logic [16:0] m_data;
  logic [23:0] m_ts;

  function automatic void m_err();
    exp_q.push_back({1'b0, 17'h0, 24'h0});
    mq.delete();
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    logic [23:0] p;
    mq.push_back(b);
    if (mq.size() == 1 && b > 8'd1) m_err();
    else if (mq.size() == 4 && b != 8'd0) m_err();
    else if (mq.size() == 8) begin
      if (b == 8'd0) begin
        p      = {mq[0], mq[1], mq[2]};
        m_data = p[16:0];
        m_ts   = {mq[4], mq[5], mq[6]};
        exp_q.push_back({1'b1, m_data, m_ts});
        mq.delete();
      end else m_err();
    end
  endfunction

  typedef struct packed {
    logic [3:0]  n;
    logic [63:0] b;
    logic [1:0]  nv;
    logic [1:0]  ne;
    logic [16:0] d;
    logic [23:0] t;
  } vec_t;

  vec_t vecs[7];
  int   nv0, ne0;

  initial begin
    vecs[0] = '{4'd8, 64'h01234500ABCDEF00, 2'd1, 2'd0, 17'h12345, 24'hABCDEF};
    vecs[1] = '{4'd4, 64'h0123455A00000000, 2'd0, 2'd1, 17'h12345, 24'hABCDEF};
    vecs[2] = '{4'd8, 64'h0000070000001000, 2'd1, 2'd0, 17'h00007, 24'h000010};
    vecs[3] = '{4'd1, 64'h0200000000000000, 2'd0, 2'd1, 17'h00007, 24'h000010};
    vecs[4] = '{4'd8, 64'h01FFFF000000017E, 2'd0, 2'd1, 17'h00007, 24'h000010};
    vecs[5] = '{4'd8, 64'h00FFFF0012345600, 2'd1, 2'd0, 17'h0FFFF, 24'h123456};
    vecs[6] = '{4'd8, 64'h01FFFF00FFFFFF00, 2'd1, 2'd0, 17'h1FFFF, 24'hFFFFFF};

    rx = 1'b1;
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_data", 64'(decoded_data), 64'h0);
    check("reset_ts", 64'(timestamp), 64'h0);
    check("reset_valid", 64'(frame_valid), 64'h0);
    check("reset_error", 64'(frame_error), 64'h0);
    rstn = 1'b1;
    idle_bits(2);

    for (int i = 0; i < 7; i++) begin
      nv0 = nvalid; ne0 = nerr;
      send_bytes(vecs[i].b, int'(vecs[i].n));
      idle_bits(2);
      check($sformatf("vec%0d_valid_pulses", i), 64'(nvalid - nv0), 64'(vecs[i].nv));
      check($sformatf("vec%0d_error_pulses", i), 64'(nerr - ne0), 64'(vecs[i].ne));
      check($sformatf("vec%0d_data", i), 64'(decoded_data), 64'(vecs[i].d));
      check($sformatf("vec%0d_ts", i), 64'(timestamp), 64'(vecs[i].t));
    end

    // Glitch shorter than half a bit must be rejected silently.
    nv0 = nvalid; ne0 = nerr;
    drive_bit(1'b0, CPB / 4);
    idle_bits(3);
    check("glitch_pulses", 64'((nvalid - nv0) + (nerr - ne0)), 64'h0);
    send_bytes(64'h0000010000000200, 8);
    idle_bits(2);
    check("after_glitch_valid", 64'(nvalid - nv0), 64'h1);
    check("after_glitch_data", {23'h0, decoded_data, timestamp}, {23'h0, 17'h00001, 24'h000002});

    nv0 = nvalid; ne0 = nerr;
    send_bytes(64'h01AA000000000000, 2);
    send_byte(8'h55, 1'b0);
    check("stop_err_error", 64'(nerr - ne0), 64'h1);
    check("stop_err_valid", 64'(nvalid - nv0), 64'h0);
    send_bytes(64'h0100020003040500, 8);
    idle_bits(2);
    check("after_stop_err_valid", 64'(nvalid - nv0), 64'h1);
    check("after_stop_err_data", {23'h0, decoded_data, timestamp}, {23'h0, 17'h10002, 24'h030405});

    nv0 = nvalid; ne0 = nerr;
    send_bytes(64'h0123450000000000, 4);
    idle_bits(25);
    send_bytes(64'h00FFFF0012345600, 8);
    idle_bits(2);
    check("idle_resync_valid", 64'(nvalid - nv0), 64'h1);
    check("idle_resync_error", 64'(nerr - ne0), 64'h0);
    check("idle_resync_data", {23'h0, decoded_data, timestamp}, {23'h0, 17'h0FFFF, 24'h123456});

    nv0 = nvalid; ne0 = nerr;
    send_bytes(64'h0111220033000000, 5);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB / 2);
    rx = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_outputs", {21'h0, decoded_data, timestamp, frame_valid, frame_error}, 64'h0);
    rstn = 1'b1;
    idle_bits(1);
    send_bytes(64'h010ABC00DEF01200, 8);
    idle_bits(2);
    check("after_reset_valid", 64'(nvalid - nv0), 64'h1);
    check("after_reset_error", 64'(nerr - ne0), 64'h0);
    check("after_reset_data", {23'h0, decoded_data, timestamp}, {23'h0, 17'h10ABC, 24'hDEF012});

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle_bits(1);
    mq.delete(); exp_q.delete(); obs_q.delete();
    m_data = '0; m_ts = '0;
    rec_en = 1'b1;
    for (int it = 0; it < 25; it++) begin
      logic [7:0] fb[8];
      int bad_k;
      if ($urandom_range(0, 9) == 0) begin
        idle_bits(25);
        mq.delete();
      end else idle_bits(int'($urandom_range(0, 2)));
      for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
      if ($urandom_range(0, 7) != 0) fb[0] = 8'($urandom_range(0, 1));
      if ($urandom_range(0, 7) != 0) fb[3] = 8'h00;
      if ($urandom_range(0, 7) != 0) fb[7] = 8'h00;
      bad_k = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
      for (int i = 0; i < 8; i++) begin
        if (i == bad_k) begin
          send_byte(fb[i], 1'b0);
          m_err();
        end else begin
          send_byte(fb[i], 1'b1);
          m_byte(fb[i]);
        end
      end
    end
    idle_bits(2);
    rec_en = 1'b0;
    check("rand_event_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("rand_event%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
    check("rand_final_outputs", {23'h0, decoded_data, timestamp}, {23'h0, m_data, m_ts});
    check("pulse_overlap", 64'(overlap), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, is the number of clk_12MHz cycles per UART bit (115200 baud).
REQ-002 Parameter IDLE_BITS, default 20, is the idle-line duration in bit periods that forces frame resynchronisation.
REQ-003 clk_12MHz  input  1  is the system clock; every flop is clocked on its rising edge.
REQ-004 rstn  input  1  is the reset: synchronous, active-low.
REQ-005 rx  input  1  is the asynchronous UART line, 8N1, LSB first, idle high.
REQ-006 decoded_data  output  17  holds the last valid frame payload, registered.
REQ-007 timestamp  output  24  holds the last valid frame timestamp, registered.
REQ-008 frame_valid  output  1  is a one-cycle pulse indicating that decoded_data and timestamp are newly updated.
REQ-009 frame_error  output  1  is a one-cycle pulse indicating that a frame or byte was discarded.

Function
REQ-010 rx SHALL pass through a 2-flop synchroniser reset to 1; all logic uses the synchronised value rx_s.
REQ-011 The byte receiver SHALL have states IDLE, START, DATA and STOP.
REQ-012 In IDLE, rx_s=0 SHALL move to START and clear the bit-timer.
REQ-013 In START, after CLKS_PER_BIT/2 cycles, rx_s=0 SHALL go to DATA and rx_s=1 SHALL return to IDLE as a false start, with no error.
REQ-014 In DATA, rx_s SHALL be sampled every CLKS_PER_BIT cycles into 8 bits, LSB first; after bit 7 the receiver SHALL go to STOP.
REQ-015 In STOP, after CLKS_PER_BIT cycles, rx_s=1 SHALL produce a one-cycle internal byte_done pulse with the byte, then return to IDLE.
REQ-016 In STOP, rx_s=0 SHALL signal a stop error, discard the byte and return to IDLE.
REQ-017 The frame is 8 bytes: B0 B1 B2 0x00 B3 B4 B5 0x00, where payload = {B0,B1,B2}[16:0] and timestamp = {B3,B4,B5}, MSB first.
REQ-018 A 3-bit byte index SHALL start at 0, advance on each byte_done, and wrap 7->0.
REQ-019 A frame SHALL be valid only if byte 0 is 0x00 or 0x01, byte 3 is 0x00 and byte 7 is 0x00.
REQ-020 Bytes SHALL be assembled into shadow registers; decoded_data and timestamp SHALL update only on a valid frame.
REQ-021 On byte_done of byte 7 of a valid frame, the next cycle SHALL assert frame_valid for 1 cycle with the outputs updated in that same cycle.
REQ-022 On any validity violation, the next cycle SHALL assert frame_error for 1 cycle, force the byte index to 0 and leave the outputs unchanged.
REQ-023 A validity violation at byte 0 or byte 3 SHALL be detected immediately on that byte, without waiting for byte 7.
REQ-024 A stop error SHALL assert frame_error for 1 cycle and force the byte index to 0.
REQ-025 An idle counter SHALL count cycles while the receiver is in IDLE and rx_s=1, and SHALL clear on any other condition.
REQ-026 On reaching CLKS_PER_BIT*IDLE_BITS cycles, the idle counter SHALL force the byte index to 0, saturate, and raise no error pulse.
REQ-027 frame_valid and frame_error SHALL never be asserted in the same cycle.
REQ-028 Back-to-back frames with zero inter-byte gap SHALL be received without loss.

Reset
REQ-029 While rstn=0: receiver state = IDLE, byte index = 0, shadow registers = 0, decoded_data = 0, timestamp = 0, frame_valid = 0, frame_error = 0, idle counter = 0, synchroniser = 1.
REQ-030 Reset asserted mid-byte or mid-frame SHALL abandon it; the first start bit after release SHALL be treated as byte 0.

Verification
REQ-031 Frame 01 23 45 00 AB CD EF 00 at 115200 baud -> exactly one frame_valid pulse, decoded_data=17'h12345, timestamp=24'hABCDEF.
REQ-032 Frame 01 23 45 5A ... -> frame_error pulse after byte 3, no frame_valid, outputs unchanged; the following clean frame 00 00 07 00 00 00 10 00 -> decoded_data=17'h00007, timestamp=24'h000010.
REQ-033 rx low for 20 cycles then high -> no byte_done, no error, receiver back in IDLE.
REQ-034 Byte 0x55 sent with stop bit driven low -> frame_error pulse, byte index 0.
REQ-035 4 bytes of a frame, then 25 bit-times idle, then full frame 00 FF FF 00 12 34 56 00 -> one frame_valid, decoded_data=17'h0FFFF, timestamp=24'h123456.
REQ-036 rstn pulsed low during byte 5 -> all outputs 0; the next full frame is decoded correctly.
